// File: rtl/iodelay_tap_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : iodelay_tap_sequencer
// Description : Turns a software command word into one-tap-at-a-time IODELAY
//               CE/INC/RST pulse trains and tracks the tap of every lane.
// Revision    : 1.0 - initial release
// ============================================================================
module iodelay_tap_sequencer #(
    parameter int N_LANES    = 8,
    parameter int TAP_W      = 6,
    parameter int SETTLE_CYC = 4,
    parameter int RST_CYC    = 2
) (
    input  logic               user_clk,
    input  logic               user_rst_n,
    input  logic [31:0]        cfg_word,
    output logic [N_LANES-1:0] dly_ce,
    output logic               dly_inc,
    output logic               dly_rst,
    output logic               busy,
    output logic [31:0]        status_word
);

    localparam int c_MAX_LANES = 8;
    localparam int c_CNT_MAX   = (SETTLE_CYC > RST_CYC) ? SETTLE_CYC : RST_CYC;
    localparam int c_CNT_W     = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_RST_LAST    = c_CNT_W'(RST_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_RSTP   = 3'd1,
        S_IDLE   = 3'd2,
        S_LOAD   = 3'd3,
        S_CMP    = 3'd4,
        S_STEP   = 3'd5,
        S_SETTLE = 3'd6
    } state_t;

    state_t             r_state;
    logic [31:0]        r_cfg_q;
    logic               r_tog_last;
    logic               r_pend;
    logic [2:0]         r_pend_lane;
    logic [TAP_W-1:0]   r_pend_tgt;
    logic               r_pend_rall;
    logic [2:0]         r_req_lane;
    logic [TAP_W-1:0]   r_req_tgt;
    logic               r_req_rall;
    logic [2:0]         r_lane;
    logic [TAP_W-1:0]   r_tgt;
    logic               r_err;
    logic               r_from_rst;
    logic [c_CNT_W-1:0] r_cnt;
    logic [TAP_W-1:0]   r_tap [c_MAX_LANES];

    logic                   w_cmd;
    logic [TAP_W-1:0]       w_cur;
    logic [N_LANES-1:0]     w_ce_onehot;
    logic [c_MAX_LANES-1:0] w_lane_valid;
    logic [31:0]            w_status;
    logic                   w_unused_cfg;

    assign w_cmd        = r_cfg_q[31] != r_tog_last;
    assign w_cur        = r_tap[r_lane];
    assign w_unused_cfg = ^r_cfg_q;

    // Full 3-bit lane field is decoded; lanes at or above N_LANES are rejected.
    for (genvar i = 0; i < c_MAX_LANES; i++) begin : g_lane_valid
        assign w_lane_valid[i] = (i < N_LANES);
    end

    for (genvar i = 0; i < N_LANES; i++) begin : g_ce_onehot
        assign w_ce_onehot[i] = (r_lane == 3'(i));
    end

    always_comb begin
        w_status            = '0;
        w_status[TAP_W-1:0] = w_cur;
        w_status[10:8]      = r_lane;
        w_status[16]        = busy;
        w_status[17]        = r_err;
        w_status[18]        = r_pend;
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_state     <= S_INIT;
            r_cfg_q     <= '0;
            r_tog_last  <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_lane <= '0;
            r_pend_tgt  <= '0;
            r_pend_rall <= 1'b0;
            r_req_lane  <= '0;
            r_req_tgt   <= '0;
            r_req_rall  <= 1'b0;
            r_lane      <= '0;
            r_tgt       <= '0;
            r_err       <= 1'b0;
            r_from_rst  <= 1'b0;
            r_cnt       <= '0;
            for (int i = 0; i < c_MAX_LANES; i++) r_tap[i] <= '0;
            dly_ce      <= '0;
            dly_inc     <= 1'b0;
            dly_rst     <= 1'b0;
            busy        <= 1'b1;
            status_word <= '0;
        end else begin
            r_cfg_q     <= cfg_word;
            status_word <= w_status;

            // Any toggle seen outside IDLE lands in the single pending slot.
            if (w_cmd && r_state != S_IDLE) begin
                r_tog_last  <= r_cfg_q[31];
                r_pend      <= 1'b1;
                r_pend_lane <= r_cfg_q[10:8];
                r_pend_tgt  <= r_cfg_q[TAP_W-1:0];
                r_pend_rall <= r_cfg_q[30];
            end

            case (r_state)
                S_INIT: begin
                    r_state <= S_RSTP;
                    r_cnt   <= '0;
                    dly_rst <= 1'b1;
                    busy    <= 1'b1;
                end
                S_RSTP: begin
                    for (int i = 0; i < c_MAX_LANES; i++) r_tap[i] <= '0;
                    if (r_cnt == c_RST_LAST) begin
                        dly_rst    <= 1'b0;
                        r_from_rst <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= S_SETTLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (r_pend) begin
                        r_pend     <= 1'b0;
                        r_req_lane <= r_pend_lane;
                        r_req_tgt  <= r_pend_tgt;
                        r_req_rall <= r_pend_rall;
                        busy       <= 1'b1;
                        r_state    <= S_LOAD;
                    end else if (w_cmd) begin
                        r_tog_last <= r_cfg_q[31];
                        r_req_lane <= r_cfg_q[10:8];
                        r_req_tgt  <= r_cfg_q[TAP_W-1:0];
                        r_req_rall <= r_cfg_q[30];
                        busy       <= 1'b1;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (r_req_rall) begin
                        r_err   <= 1'b0;
                        r_cnt   <= '0;
                        dly_rst <= 1'b1;
                        r_state <= S_RSTP;
                    end else if (!w_lane_valid[r_req_lane]) begin
                        r_err   <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_lane  <= r_req_lane;
                        r_tgt   <= r_req_tgt;
                        r_state <= S_CMP;
                    end
                end
                S_CMP: begin
                    if (w_cur == r_tgt) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        dly_inc <= (r_tgt > w_cur);
                        dly_ce  <= w_ce_onehot;
                        r_state <= S_STEP;
                    end
                end
                S_STEP: begin
                    dly_ce <= '0;
                    if (dly_inc) r_tap[r_lane] <= w_cur + 1'b1;
                    else         r_tap[r_lane] <= w_cur - 1'b1;
                    r_from_rst <= 1'b0;
                    r_cnt      <= '0;
                    r_state    <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_cnt == c_SETTLE_LAST) begin
                        r_cnt <= '0;
                        if (r_from_rst) begin
                            busy    <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_CMP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    dly_ce  <= '0;
                    dly_rst <= 1'b0;
                    busy    <= 1'b1;
                    r_state <= S_INIT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
